// File: rtl/crc_pkg.sv
// Shared command encodings and controller state type for the CRC engine arbiter.
package crc_pkg;

  localparam logic [1:0] CMD_INIT  = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_CHECK = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    DATA     = 3'd2,
    CHECK    = 3'd3,
    WAIT_RES = 3'd4,
    REPORT   = 3'd5
  } state_t;

endpackage

// File: rtl/crc_arbiter_rr.sv
// Round-robin picker: first requester strictly after last_grant (mod NREQ) wins.
module rr_arbiter
  import crc_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  // Scan from last_grant+1 around the ring; the first active request is granted.
  always_comb begin
    logic found_s;
    int   idx_s;
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    idx_s    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(last_grant) + k) % NREQ;
      if (!found_s && req[idx_s[IDW-1:0]]) begin
        grant[idx_s[IDW-1:0]] = 1'b1;
        grant_id              = idx_s[IDW-1:0];
        found_s               = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/crc_arbiter.sv
// Shares one CRC compute engine among NREQ requesters: grants a job, streams
// INIT/DATA/CHECK words to the engine and returns the engine's verdict.
module crc_arbiter
  import crc_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int W    = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0][W-1:0]  req_len,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         dat_valid,
  input  logic [NREQ-1:0][W-1:0]  dat_data,
  output logic [NREQ-1:0]         dat_ready,
  output logic                    eng_valid,
  output logic [1:0]              eng_cmd,
  output logic [W-1:0]            eng_dat,
  input  logic                    eng_ready,
  input  logic                    eng_res_valid,
  input  logic                    eng_res_match,
  output logic [NREQ-1:0]         res_valid,
  output logic                    res_match,
  input  logic [NREQ-1:0]         res_ready,
  output logic                    mon_valid,
  output logic                    mon_match,
  output logic [IDW-1:0]          mon_id
);

  state_t          state_r, state_nx_s;
  logic [IDW-1:0]  grant_r, last_grant_r;
  logic [W-1:0]    cnt_r;
  logic            match_r, mon_valid_r;
  logic [NREQ-1:0] rr_grant_s;
  logic [IDW-1:0]  rr_id_s;
  logic            accept_s, dec_s, take_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (rr_grant_s),
    .grant_id   (rr_id_s)
  );

  // Next-state and output decode; rst forces every output low in the same cycle.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    dec_s      = 1'b0;
    take_s     = 1'b0;
    req_ready  = '0;
    dat_ready  = '0;
    eng_valid  = 1'b0;
    eng_cmd    = 2'd0;
    eng_dat    = '0;
    res_valid  = '0;
    res_match  = 1'b0;
    mon_valid  = 1'b0;
    mon_match  = 1'b0;
    mon_id     = '0;
    if (!rst) begin
      mon_valid = mon_valid_r;
      mon_match = mon_valid_r & match_r;
      mon_id    = mon_valid_r ? grant_r : '0;
      case (state_r)
        IDLE: begin
          req_ready = rr_grant_s;
          if (|req_valid) begin
            accept_s   = 1'b1;
            state_nx_s = INIT;
          end else begin
          end
        end
        INIT: begin
          eng_valid = 1'b1;
          eng_cmd   = CMD_INIT;
          if (eng_ready) begin
            if (cnt_r == '0) begin
              state_nx_s = CHECK;
            end else begin
              state_nx_s = DATA;
            end
          end else begin
          end
        end
        // Data and check words pass straight through with no added latency.
        DATA: begin
          eng_valid          = dat_valid[grant_r];
          eng_cmd            = CMD_DATA;
          eng_dat            = dat_data[grant_r];
          dat_ready[grant_r] = eng_ready;
          if (dat_valid[grant_r] && eng_ready) begin
            dec_s = 1'b1;
            if (cnt_r == W'(1)) begin
              state_nx_s = CHECK;
            end else begin
            end
          end else begin
          end
        end
        CHECK: begin
          eng_valid          = dat_valid[grant_r];
          eng_cmd            = CMD_CHECK;
          eng_dat            = dat_data[grant_r];
          dat_ready[grant_r] = eng_ready;
          if (dat_valid[grant_r] && eng_ready) begin
            state_nx_s = WAIT_RES;
          end else begin
          end
        end
        WAIT_RES: begin
          if (eng_res_valid) begin
            take_s     = 1'b1;
            state_nx_s = REPORT;
          end else begin
          end
        end
        REPORT: begin
          res_valid[grant_r] = 1'b1;
          res_match          = match_r;
          if (res_ready[grant_r]) begin
            state_nx_s = IDLE;
          end else begin
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end else begin
    end
  end

  // Controller state, job context and the one-cycle monitor pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= IDW'(NREQ - 1);
      cnt_r        <= '0;
      match_r      <= 1'b0;
      mon_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      mon_valid_r <= take_s;
      if (accept_s) begin
        grant_r      <= rr_id_s;
        last_grant_r <= rr_id_s;
        cnt_r        <= req_len[rr_id_s];
      end else if (dec_s) begin
        cnt_r <= cnt_r - W'(1);
      end
      if (take_s) begin
        match_r <= eng_res_match;
      end
    end
  end

endmodule

// File: tb/tb_crc_arbiter.sv
// Self-checking bench for crc_arbiter: randomized jobs compared against an
// expected engine transcript, round-robin order and verdict routing.
module tb_crc_arbiter;
  import crc_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_len;
  logic [1:0]      req_ready;
  logic [1:0]      dat_valid;
  logic [1:0][7:0] dat_data;
  logic [1:0]      dat_ready;
  logic            eng_valid;
  logic [1:0]      eng_cmd;
  logic [7:0]      eng_dat;
  logic            eng_ready;
  logic            eng_res_valid, eng_res_match;
  logic [1:0]      res_valid;
  logic            res_match;
  logic [1:0]      res_ready;
  logic            mon_valid, mon_match;
  logic [0:0]      mon_id;

  int         nassert = 0;
  int         nfail   = 0;
  int         last_m  = 1;
  int         id, len;
  bit         m;
  logic [7:0] wbuf [0:255];

  crc_arbiter #(.NREQ(2), .W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .dat_valid(dat_valid), .dat_data(dat_data), .dat_ready(dat_ready),
    .eng_valid(eng_valid), .eng_cmd(eng_cmd), .eng_dat(eng_dat), .eng_ready(eng_ready),
    .eng_res_valid(eng_res_valid), .eng_res_match(eng_res_match),
    .res_valid(res_valid), .res_match(res_match), .res_ready(res_ready),
    .mon_valid(mon_valid), .mon_match(mon_match), .mon_id(mon_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({req_ready, dat_ready, eng_valid, eng_cmd, eng_dat,
                res_valid, res_match, mon_valid, mon_match, mon_id});
  endfunction

  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= 2; k++) begin
      if (v[(last + k) % 2]) return (last + k) % 2;
    end
    return 0;
  endfunction

  task automatic fill(input int n);
    for (int k = 0; k <= n; k++) wbuf[k] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; dat_valid = 2'b00; res_ready = 2'b00;
    eng_ready = 1'b0; eng_res_valid = 1'b0; eng_res_match = 1'b0;
    req_len = '0; dat_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = 1;
    @(negedge clk);
    check("post_reset_outputs", outs(), 32'd0);
    @(posedge clk); #1;
  endtask

  // One job for requester jid; a pending request on the other port is left alone.
  task automatic run_job(input int jid, input int jlen, input bit jm, input bit rnd,
                         input int hold, input bit b2b, input int abort_n);
    logic [1:0] e_cmd[$], o_cmd[$];
    logic [7:0] e_dat[$], o_dat[$];
    int  widx = 0, nmon = 0, acc_cyc = -1, resp = -1, nbad = 0, budget;
    bit  accepted = 0, checked = 0, done = 0, aborted = 0, others_ok = 1, pulse;
    e_cmd.push_back(CMD_INIT); e_dat.push_back(8'h00);
    for (int k = 0; k < jlen; k++) begin e_cmd.push_back(CMD_DATA); e_dat.push_back(wbuf[k]); end
    e_cmd.push_back(CMD_CHECK); e_dat.push_back(wbuf[jlen]);
    budget = 8 * jlen + 60 + hold;
    req_valid[jid] = 1'b1;
    req_len[jid]   = 8'(jlen);
    for (int cyc = 0; cyc < budget && !done && !aborted; cyc++) begin
      eng_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (widx <= jlen) begin
        dat_valid[jid] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        dat_data[jid]  = wbuf[widx];
      end else begin
        dat_valid[jid] = 1'b0;
        dat_data[jid]  = 8'($urandom);
      end
      pulse = (resp == 0);
      if (resp >= 0) resp--;
      eng_res_valid = 1'b0; eng_res_match = 1'b0;
      if (pulse) begin
        eng_res_valid = 1'b1; eng_res_match = jm;
      end else if (!checked && rnd && $urandom_range(0, 3) == 0) begin
        eng_res_valid = 1'b1; eng_res_match = ~jm;
      end
      res_ready[jid] = (hold == 0);
      @(negedge clk);
      for (int j = 0; j < 2; j++)
        if (j != jid && (req_ready[j] | dat_ready[j] | res_valid[j])) others_ok = 0;
      if (!accepted && req_ready != 2'b00) begin
        check("grant_onehot", 32'(req_ready), 32'(2'b01 << jid));
        if (req_ready[jid]) begin accepted = 1; acc_cyc = cyc; last_m = jid; end
      end
      if (eng_valid && eng_ready) begin
        o_cmd.push_back(eng_cmd); o_dat.push_back(eng_dat);
        if (eng_cmd == CMD_CHECK) begin checked = 1; resp = rnd ? int'($urandom_range(0, 2)) : 0; end
      end
      if (dat_valid[jid] && dat_ready[jid]) widx++;
      if (mon_valid) begin
        nmon++;
        check("mon_match", 32'(mon_match), 32'(jm));
        check("mon_id", 32'(mon_id), 32'(jid));
      end
      if (res_valid[jid]) begin
        check("res_match", 32'(res_match), 32'(jm));
        if (res_ready[jid]) done = 1;
        else if (hold > 0) hold--;
      end
      if (abort_n > 0 && widx == abort_n) aborted = 1;
      @(posedge clk); #1;
      if (accepted) req_valid[jid] = 1'b0;
    end
    if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      check("abort_during_reset", outs(), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; last_m = 1;
      dat_valid = 2'b00; eng_res_valid = 1'b1; eng_res_match = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("abort_idle_outputs", outs(), 32'd0);
        @(posedge clk); #1;
      end
      eng_res_valid = 1'b0; eng_res_match = 1'b0;
    end else begin
      check("job_done", 32'(done), 32'd1);
      check("eng_count", 32'(o_cmd.size()), 32'(e_cmd.size()));
      for (int k = 0; k < o_cmd.size() && k < e_cmd.size(); k++)
        if (o_cmd[k] !== e_cmd[k] || o_dat[k] !== e_dat[k]) nbad++;
      check("eng_sequence_bad_words", 32'(nbad), 32'd0);
      check("mon_pulses", 32'(nmon), 32'd1);
      check("others_quiet", 32'(others_ok), 32'd1);
      if (b2b) check("b2b_accept_cycle", 32'(acc_cyc), 32'd0);
      dat_valid[jid] = 1'b0; res_ready[jid] = 1'b0; eng_res_valid = 1'b0;
    end
  endtask

  initial begin
    do_reset();

    // Directed job: len 3, fixed words, matching verdict.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'hA5;
    id = rr_pick(2'b01, last_m);
    run_job(id, 3, 1'b1, 1'b0, 0, 1'b0, 0);

    // Zero-length job on requester 1.
    fill(0);
    id = rr_pick(2'b10, last_m);
    run_job(id, 0, 1'b0, 1'b0, 0, 1'b0, 0);

    // Len 5 with random engine/data stalls and stray engine verdicts.
    fill(5);
    m  = 1'($urandom);
    id = rr_pick(2'b01, last_m);
    run_job(id, 5, m, 1'b1, 0, 1'b0, 0);

    // Maximum length.
    fill(255);
    id = rr_pick(2'b10, last_m);
    run_job(id, 255, 1'b1, 1'b0, 0, 1'b0, 0);

    // Contention after reset; last job holds res_ready low with the other pending.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      req_valid = 2'b11;
      req_len   = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      len = int'($urandom_range(0, 4));
      fill(len);
      m  = 1'($urandom);
      id = rr_pick(2'b11, last_m);
      run_job(id, len, m, 1'b1, (j == 3) ? 10 : 0, j > 0, 0);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Reset after two of four data words, then a clean job.
    fill(4);
    id = rr_pick(2'b01, last_m);
    run_job(id, 4, 1'b1, 1'b0, 0, 1'b0, 2);
    req_valid[1] = 1'b1;
    req_len[1]   = 8'd2;
    fill(4);
    id = rr_pick(2'b11, last_m);
    run_job(id, 4, 1'b0, 1'b1, 0, 1'b0, 0);
    req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/crc_arbiter.md
CRC_ARBITER -- requirements
Module: crc_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one CRC compute engine.
REQ-002 Parameter W, default 8, width of data, length and CRC words.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NREQ  requester i has a job; req_len[i] valid with it.
REQ-006 req_len  in  NREQ x W  number of data words in job i (0..2^W-1).
REQ-007 req_ready  out  NREQ  job accept, one-hot, only to granted requester.
REQ-008 dat_valid / dat_data / dat_ready  in / in / out  NREQ, NREQ x W, NREQ  per-requester data stream: len data words, then one expected-CRC word.
REQ-009 eng_valid / eng_cmd / eng_dat / eng_ready  out / out 2 / out W / in  command+word channel to the engine.
REQ-010 eng_res_valid / eng_res_match  in 1 / in 1  engine verdict, one-cycle pulse, always accepted.
REQ-011 res_valid / res_match / res_ready  out NREQ / out 1 / in NREQ  verdict returned to the granted requester.
REQ-012 mon_valid / mon_match / mon_id  out 1 / out 1 / out clog2(NREQ)  monitor notification, no backpressure.

Function
REQ-013 States: IDLE, INIT, DATA, CHECK, WAIT_RES, REPORT; exactly one active.
REQ-014 IDLE: if any req_valid, assert req_ready to round-robin winner same cycle; on handshake latch grant id and len, go INIT.
REQ-015 Round robin: the winner is the first requester after last_grant (mod NREQ) with req_valid set; last_grant updates on each accept.
REQ-016 INIT: eng_valid=1, eng_cmd=1, eng_dat=0 until eng_ready; then DATA if len>0 else CHECK.
REQ-017 DATA: eng_cmd=2, eng_dat=dat_data[g], eng_valid=dat_valid[g], dat_ready[g]=eng_ready (combinational pass-through, zero added latency); remaining count decrements per handshake; at count 1 handshake go CHECK.
REQ-018 CHECK: same pass-through with eng_cmd=3 for exactly one word; on handshake go WAIT_RES.
REQ-019 WAIT_RES: all ready/valid outputs 0; on eng_res_valid latch match, pulse mon_valid one cycle with mon_match, mon_id=g, go REPORT.
REQ-020 REPORT: res_valid[g]=1, res_match held stable until res_ready[g]; then IDLE.
REQ-021 Non-granted requesters see req_ready=dat_ready=res_valid=0 at all times.
REQ-022 Length counter is W bits, no wrap: len=2^W-1 yields exactly 2^W-1 DATA words.
REQ-023 eng_res_valid outside WAIT_RES is ignored.
REQ-024 Back-to-back: REPORT->IDLE->accept costs one idle cycle minimum.

Reset
REQ-025 rst asserted at any state, including mid-job, forces IDLE next edge; grant, count, match cleared; last_grant=NREQ-1 so requester 0 wins first.
REQ-026 During and after reset all outputs 0; an aborted job produces no res_valid or mon_valid.

Structure
REQ-027 Shared package crc_pkg holds command constants CMD_INIT=1, CMD_DATA=2, CMD_CHECK=3 and the state enum.
REQ-028 Round-robin selection is a sub-module rr_arbiter (request vector, last_grant in; one-hot grant out).

Verification
REQ-029 Req0 len=3, data 0x11,0x22,0x33, check 0xA5, engine match=1 -> engine sees cmds 1,2,2,2,3 with those words; res_match=1 on res_valid[0]; mon_id=0.
REQ-030 Req0 and req1 valid same cycle after reset -> req0 granted first, req1 second; repeated contention alternates 0,1,0,1.
REQ-031 len=0 -> cmds 1 then 3 only; check word forwarded; verdict returned.
REQ-032 eng_ready and dat_valid toggled randomly during len=5 job -> exactly 5 DATA and 1 CHECK handshakes, no duplicated or dropped words.
REQ-033 rst asserted in DATA after 2 of 4 words -> IDLE next cycle, all outputs 0, no res_valid/mon_valid; new job then completes normally.
REQ-034 res_ready[1] held low 10 cycles in REPORT -> res_valid[1], res_match stable; req0 pending not accepted until release.
